// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time-clock core.
// Provides the time-field widths, their moduli and the packed time record
// used by rtc_core.
package rtc_pkg;

  localparam int HR_W  = 5;
  localparam int MIN_W = 6;
  localparam int SEC_W = 6;

  localparam int HRS  = 24;
  localparam int MINS = 60;
  localparam int SECS = 60;

  typedef struct packed {
    logic [HR_W-1:0]  hr;
    logic [MIN_W-1:0] min;
    logic [SEC_W-1:0] sec;
  } time_t;

endpackage

// File: rtl/rtc_core_mod_counter.sv
// Modulo-MOD counter with synchronous clear, parallel load and increment.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clr             synchronous clear to 0 (beats ld and inc)
//   ld, ld_val      parallel load (beats inc)
//   inc             count up by one, wrapping MOD-1 -> 0
//   q               current count
//   carry           high while inc is applied at MOD-1 (wrap about to happen)
module mod_counter #(
  parameter int WIDTH = 4,
  parameter int MOD   = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             inc,
  output logic [WIDTH-1:0] q,
  output logic             carry
);

  assign carry = inc & (q == WIDTH'(MOD - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (inc) begin
      q <= carry ? '0 : q + 1'b1;
    end
  end

endmodule

// File: rtl/rtc_core.sv
// Real-time-clock core: one authoritative 24 h hh:mm:ss chain advanced by an
// internal prescaler, with a derived 12 h display view, load, per-field set
// increments and an alarm-match pulse.
// Ports:
//   clk, RESET                  clock, synchronous active-high reset
//   en                          run enable (freezes prescaler and time when low)
//   mode12                      1 = 12 h display view, 0 = 24 h
//   ld, ld_hr/ld_min/ld_sec     load strobe and 24 h binary values
//   inc_hr, inc_min             one-cycle set pulses (no carry into next field)
//   al_en, al_hr/al_min         alarm enable and alarm time
//   hr24/min/sec                current time, binary
//   hr_disp, pm, bcd            display hour, PM flag, {hr, min} BCD digits
//   tick_sec, roll_day          pulses: tick advance, midnight rollover
//   ld_err, al_match            pulses: rejected load, alarm hit
module rtc_core
  import rtc_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             en,
  input  logic             mode12,
  input  logic             ld,
  input  logic [HR_W-1:0]  ld_hr,
  input  logic [MIN_W-1:0] ld_min,
  input  logic [SEC_W-1:0] ld_sec,
  input  logic             inc_hr,
  input  logic             inc_min,
  input  logic             al_en,
  input  logic [HR_W-1:0]  al_hr,
  input  logic [MIN_W-1:0] al_min,
  output logic [HR_W-1:0]  hr24,
  output logic [MIN_W-1:0] min,
  output logic [SEC_W-1:0] sec,
  output logic [HR_W-1:0]  hr_disp,
  output logic             pm,
  output logic [15:0]      bcd,
  output logic             tick_sec,
  output logic             roll_day,
  output logic             ld_err,
  output logic             al_match
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int PW   = $clog2(DIV);

  time_t          now;
  logic [PW-1:0]  presc;
  logic           pre_wrap;
  logic           ld_ok, set_hr, set_min, set_any, adv;
  logic           sec_c, min_c, hr_c, min_inc, hr_inc;
  logic [MIN_W-1:0] nxt_min;
  logic [HR_W-1:0]  nxt_hr;
  logic           al_hit;

  function automatic logic [HR_W-1:0] to_12h(input logic [HR_W-1:0] h);
    if (h == '0)                   return HR_W'(12);
    else if (h > HR_W'(12))        return h - HR_W'(12);
    else                           return h;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Load beats set pulses, which beat the tick; a blocked tick is dropped.
  assign ld_ok   = ld && (ld_hr <= HR_W'(HRS - 1)) && (ld_min <= MIN_W'(MINS - 1))
                      && (ld_sec <= SEC_W'(SECS - 1));
  assign set_hr  = ~ld & inc_hr;
  assign set_min = ~ld & inc_min;
  assign set_any = set_hr | set_min;
  assign adv     = pre_wrap & ~ld & ~set_any;

  mod_counter #(.WIDTH(PW), .MOD(DIV)) u_presc (
    .clk(clk), .rst(RESET), .clr(ld_ok | set_any), .ld(1'b0), .ld_val('0),
    .inc(en), .q(presc), .carry(pre_wrap)
  );

  mod_counter #(.WIDTH(SEC_W), .MOD(SECS)) u_sec (
    .clk(clk), .rst(RESET), .clr(set_min), .ld(ld_ok), .ld_val(ld_sec),
    .inc(adv), .q(now.sec), .carry(sec_c)
  );

  // A set pulse on minutes may wrap 59 -> 0 but must never carry into hours.
  assign min_inc = sec_c | set_min;
  assign hr_inc  = set_hr | (sec_c & min_c);

  mod_counter #(.WIDTH(MIN_W), .MOD(MINS)) u_min (
    .clk(clk), .rst(RESET), .clr(1'b0), .ld(ld_ok), .ld_val(ld_min),
    .inc(min_inc), .q(now.min), .carry(min_c)
  );

  mod_counter #(.WIDTH(HR_W), .MOD(HRS)) u_hr (
    .clk(clk), .rst(RESET), .clr(1'b0), .ld(ld_ok), .ld_val(ld_hr),
    .inc(hr_inc), .q(now.hr), .carry(hr_c)
  );

  // Alarm compares against the time the advance is about to produce, so the
  // registered pulse lines up with the first cycle that time is visible.
  // The predicted values are always in range, so bad alarm settings never hit.
  assign nxt_min = (now.min == MIN_W'(MINS - 1)) ? '0 : now.min + 1'b1;
  assign nxt_hr  = (now.min != MIN_W'(MINS - 1)) ? now.hr :
                   (now.hr == HR_W'(HRS - 1))    ? '0     : now.hr + 1'b1;
  assign al_hit  = adv & al_en & (now.sec == SEC_W'(SECS - 1))
                 & (nxt_min == al_min) & (nxt_hr == al_hr);

  always_ff @(posedge clk) begin
    if (RESET) begin
      tick_sec <= 1'b0;
      roll_day <= 1'b0;
      ld_err   <= 1'b0;
      al_match <= 1'b0;
    end else begin
      tick_sec <= adv;
      roll_day <= sec_c & min_c & hr_c;
      ld_err   <= ld & ~ld_ok;
      al_match <= al_hit;
    end
  end

  assign hr24    = now.hr;
  assign min     = now.min;
  assign sec     = now.sec;
  assign pm      = (now.hr >= HR_W'(12));
  assign hr_disp = mode12 ? to_12h(now.hr) : now.hr;
  assign bcd     = {to_bcd({1'b0, hr_disp}), to_bcd(now.min)};

endmodule

// File: tb/tb_rtc_core.sv
module tb_rtc_core;

  logic        clk;
  logic        RESET;
  logic        en, mode12, ld, inc_hr, inc_min, al_en;
  logic [4:0]  ld_hr, al_hr;
  logic [5:0]  ld_min, ld_sec, al_min;
  logic [4:0]  hr24, hr_disp;
  logic [5:0]  min, sec;
  logic        pm, tick_sec, roll_day, ld_err, al_match;
  logic [15:0] bcd;

  int n_checks = 0;
  int n_bad    = 0;

  rtc_core #(.CLK_HZ(10), .TICK_HZ(1)) dut (
    .clk(clk), .RESET(RESET), .en(en), .mode12(mode12), .ld(ld),
    .ld_hr(ld_hr), .ld_min(ld_min), .ld_sec(ld_sec),
    .inc_hr(inc_hr), .inc_min(inc_min),
    .al_en(al_en), .al_hr(al_hr), .al_min(al_min),
    .hr24(hr24), .min(min), .sec(sec), .hr_disp(hr_disp), .pm(pm), .bcd(bcd),
    .tick_sec(tick_sec), .roll_day(roll_day), .ld_err(ld_err), .al_match(al_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       ld;
    logic [4:0] lh;
    logic [5:0] lm, ls;
    logic       ih, im, m12;
    logic [4:0] eh;
    logic [5:0] em, es;
    logic [4:0] ed;
    logic       ep;
    logic [15:0] eb;
    logic       ee;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; afterwards outputs are stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    ld = 1'b1; ld_hr = h; ld_min = m; ld_sec = s;
    step();
    ld = 1'b0;
  endtask

  // Cycles until tick_sec is seen, or -1 if none within the bound.
  task automatic wait_tick(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (tick_sec) begin
        n = i;
        break;
      end
    end
  endtask

  int n;

  initial begin
    //                ld    lh     lm     ls     ih    im    m12   eh     em     es     ed     ep    eb          ee
    vecs[0]  = '{1'b1, 5'd13, 6'd5,  6'd0,  1'b0, 1'b0, 1'b1, 5'd13, 6'd5,  6'd0,  5'd1,  1'b1, 16'h0105, 1'b0};
    vecs[1]  = '{1'b1, 5'd24, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 5'd13, 6'd5,  6'd0,  5'd1,  1'b1, 16'h0105, 1'b1};
    vecs[2]  = '{1'b1, 5'd12, 6'd0,  6'd0,  1'b0, 1'b0, 1'b1, 5'd12, 6'd0,  6'd0,  5'd12, 1'b1, 16'h1200, 1'b0};
    vecs[3]  = '{1'b1, 5'd0,  6'd30, 6'd15, 1'b0, 1'b0, 1'b0, 5'd0,  6'd30, 6'd15, 5'd0,  1'b0, 16'h0030, 1'b0};
    vecs[4]  = '{1'b1, 5'd10, 6'd59, 6'd30, 1'b0, 1'b0, 1'b0, 5'd10, 6'd59, 6'd30, 5'd10, 1'b0, 16'h1059, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b0, 1'b1, 1'b0, 5'd10, 6'd0,  6'd0,  5'd10, 1'b0, 16'h1000, 1'b0};
    vecs[6]  = '{1'b1, 5'd10, 6'd59, 6'd30, 1'b0, 1'b0, 1'b0, 5'd10, 6'd59, 6'd30, 5'd10, 1'b0, 16'h1059, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b1, 1'b1, 1'b1, 5'd11, 6'd0,  6'd0,  5'd11, 1'b0, 16'h1100, 1'b0};
    vecs[8]  = '{1'b1, 5'd23, 6'd17, 6'd42, 1'b0, 1'b0, 1'b0, 5'd23, 6'd17, 6'd42, 5'd23, 1'b1, 16'h2317, 1'b0};
    vecs[9]  = '{1'b0, 5'd0,  6'd0,  6'd0,  1'b1, 1'b0, 1'b0, 5'd0,  6'd17, 6'd42, 5'd0,  1'b0, 16'h0017, 1'b0};
    vecs[10] = '{1'b1, 5'd10, 6'd60, 6'd0,  1'b0, 1'b0, 1'b0, 5'd0,  6'd17, 6'd42, 5'd0,  1'b0, 16'h0017, 1'b1};
    vecs[11] = '{1'b1, 5'd21, 6'd45, 6'd9,  1'b0, 1'b0, 1'b1, 5'd21, 6'd45, 6'd9,  5'd9,  1'b1, 16'h0945, 1'b0};

    RESET = 1'b1; en = 1'b0; mode12 = 1'b0; ld = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
    ld_hr = '0; ld_min = '0; ld_sec = '0; al_en = 1'b0; al_hr = '0; al_min = '0;
    step(); step();

    // Reset state in both display modes.
    check("rst hr24", hr24, 0);
    check("rst min", min, 0);
    check("rst sec", sec, 0);
    check("rst hr_disp24", hr_disp, 0);
    check("rst pm", pm, 0);
    check("rst bcd24", bcd, 16'h0000);
    check("rst pulses", {tick_sec, roll_day, ld_err, al_match}, 0);
    mode12 = 1'b1; #1;
    check("rst hr_disp12", hr_disp, 12);
    check("rst bcd12", bcd, 16'h1200);
    mode12 = 1'b0;

    // First tick exactly DIV cycles after reset release; minute after 600.
    RESET = 1'b0; en = 1'b1;
    wait_tick(n);
    check("first tick cycles", n, 10);
    check("first tick sec", sec, 1);
    repeat (590) step();
    check("600cyc min", min, 1);
    check("600cyc sec", sec, 0);
    check("600cyc tick", tick_sec, 1);

    // Table-driven load / set / display vectors with time frozen.
    en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      ld = vecs[i].ld; ld_hr = vecs[i].lh; ld_min = vecs[i].lm; ld_sec = vecs[i].ls;
      inc_hr = vecs[i].ih; inc_min = vecs[i].im; mode12 = vecs[i].m12;
      step();
      ld = 1'b0; inc_hr = 1'b0; inc_min = 1'b0;
      check($sformatf("v%0d hr24", i), hr24, vecs[i].eh);
      check($sformatf("v%0d min", i), min, vecs[i].em);
      check($sformatf("v%0d sec", i), sec, vecs[i].es);
      check($sformatf("v%0d hr_disp", i), hr_disp, vecs[i].ed);
      check($sformatf("v%0d pm", i), pm, vecs[i].ep);
      check($sformatf("v%0d bcd", i), bcd, vecs[i].eb);
      check($sformatf("v%0d ld_err", i), ld_err, vecs[i].ee);
      check($sformatf("v%0d tick/alarm", i), {tick_sec, al_match}, 0);
    end
    step();
    check("ld_err one cycle", ld_err, 0);

    // Midnight rollover.
    mode12 = 1'b0;
    load(5'd23, 6'd59, 6'd58);
    en = 1'b1;
    wait_tick(n);
    check("roll t1 cycles", n, 10);
    check("roll t1 time", {hr24, min, sec}, {5'd23, 6'd59, 6'd59});
    check("roll t1 roll_day", roll_day, 0);
    wait_tick(n);
    check("roll t2 cycles", n, 10);
    check("roll t2 time", {hr24, min, sec}, 17'd0);
    check("roll t2 roll_day", roll_day, 1);
    mode12 = 1'b1; #1;
    check("roll hr_disp12", hr_disp, 12);
    check("roll pm", pm, 0);
    check("roll bcd12", bcd, 16'h1200);
    step();
    check("roll_day one cycle", roll_day, 0);

    // Alarm hit by tick, not by load; out-of-range alarm never hits.
    en = 1'b0; mode12 = 1'b0;
    al_en = 1'b1; al_hr = 5'd7; al_min = 6'd30;
    load(5'd7, 6'd29, 6'd59);
    check("alarm after load", al_match, 0);
    en = 1'b1;
    wait_tick(n);
    check("alarm tick time", {hr24, min, sec}, {5'd7, 6'd30, 6'd0});
    check("alarm match", al_match, 1);
    step();
    check("alarm one cycle", al_match, 0);
    en = 1'b0;
    load(5'd7, 6'd30, 6'd0);
    check("alarm direct load", al_match, 0);
    al_hr = 5'd24; al_min = 6'd0;
    load(5'd23, 6'd59, 6'd59);
    en = 1'b1;
    wait_tick(n);
    check("alarm bad hr rolled", {hr24, min, sec}, 17'd0);
    check("alarm bad hr no match", al_match, 0);
    al_en = 1'b0;

    // Load coinciding with prescaler wrap: tick discarded, period restarts.
    load(5'd1, 6'd0, 6'd0);
    repeat (9) step();
    ld = 1'b1; ld_hr = 5'd2; ld_min = 6'd3; ld_sec = 6'd4;
    step();
    ld = 1'b0;
    check("ld@wrap time", {hr24, min, sec}, {5'd2, 6'd3, 6'd4});
    check("ld@wrap no tick", tick_sec, 0);
    wait_tick(n);
    check("ld@wrap next tick", n, 10);
    check("ld@wrap next sec", sec, 5);

    // Enable low mid-count holds the prescaler.
    load(5'd3, 6'd0, 6'd0);
    repeat (4) step();
    en = 1'b0;
    repeat (5) step();
    check("en hold no tick", {tick_sec, sec}, 0);
    en = 1'b1;
    wait_tick(n);
    check("en resume cycles", n, 6);

    // Reset mid-count.
    repeat (3) step();
    RESET = 1'b1;
    step();
    check("midrst time", {hr24, min, sec}, 17'd0);
    check("midrst pulses", {tick_sec, roll_day, ld_err, al_match}, 0);
    RESET = 1'b0;
    wait_tick(n);
    check("midrst first tick", n, 10);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
